hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/hazard_cmp.sv | 23 ++
 rtl/hazard_ctrl.sv | 77 +++++++
 tb/tb_hazard_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard control unit.
// Configuration macro: REGFILE_BYPASS_EN (write-first regfile, WB stage not compared).
package hazard_pkg;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } sb_entry_t;

    localparam int SB_DEPTH = 3;
    localparam int SB_EX    = 0;
    localparam int SB_MEM   = 1;
    localparam int SB_WB    = 2;
    localparam int CNT_W    = 32;

`ifdef REGFILE_BYPASS_EN
    // Write-first regfile forwards the WB value, so only EX and MEM can hazard.
    localparam int SB_CMP = 2;
`else
    localparam int SB_CMP = 3;
`endif

endpackage

// File: rtl/hazard_cmp.sv
// Compares one source register address against the scoreboard stages.
// Configuration macro: REGFILE_BYPASS_EN (via hazard_pkg::SB_CMP).
module hazard_cmp
    import hazard_pkg::*;
(
    input  logic                          used,
    input  logic [4:0]                    addr,
    input  sb_entry_t [SB_DEPTH-1:0]      sb,
    output logic                          hit
);

    logic match;

    // Any valid compared stage writing the same register; x0 never matches.
    always_comb begin
        match = 1'b0;
        for (int i = 0; i < SB_CMP; i++) begin
            if (sb[i].valid && (sb[i].rd == addr)) match = 1'b1;
        end
        hit = used && (addr != 5'd0) && match;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// RAW stall / branch flush control with a 3-stage destination scoreboard.
// Configuration macro: REGFILE_BYPASS_EN (WB entry excluded from hazard compare).
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       id_rd_addr,
    input  logic             id_rd_wren,
    input  logic             ex_br_taken,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    sb_entry_t [SB_DEPTH-1:0] sb;
    sb_entry_t                ex_new;
    logic                     hit1;
    logic                     hit2;
    logic                     raw;

    hazard_cmp u_cmp_rs1 (
        .used (id_rs1_used),
        .addr (id_rs1_addr),
        .sb   (sb),
        .hit  (hit1)
    );

    hazard_cmp u_cmp_rs2 (
        .used (id_rs2_used),
        .addr (id_rs2_addr),
        .sb   (sb),
        .hit  (hit2)
    );

    // Hazard decision and control outputs; a taken branch overrides the stall.
    always_comb begin
        raw          = id_valid && (hit1 || hit2);
        pc_stall     = raw && !ex_br_taken;
        ifid_stall   = raw && !ex_br_taken;
        ifid_flush   = ex_br_taken;
        idex_flush   = raw || ex_br_taken;
        ex_new.valid = id_valid && id_rd_wren && (id_rd_addr != 5'd0) && !raw && !ex_br_taken;
        ex_new.rd    = ex_new.valid ? id_rd_addr : 5'd0;
    end

    // Scoreboard shift EX->MEM->WB; a bubble enters EX on stall or flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb <= '0;
        end else begin
            sb[SB_WB]  <= sb[SB_MEM];
            sb[SB_MEM] <= sb[SB_EX];
            sb[SB_EX]  <= ex_new;
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_stall && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
            if (ifid_flush && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl; honours REGFILE_BYPASS_EN if defined.
module tb_hazard_ctrl;

`ifdef REGFILE_BYPASS_EN
    localparam int NCMP = 2;
`else
    localparam int NCMP = 3;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs1_addr = '0;
    logic [4:0]  id_rs2_addr = '0;
    logic        id_rs1_used = 1'b0;
    logic        id_rs2_used = 1'b0;
    logic [4:0]  id_rd_addr = '0;
    logic        id_rd_wren = 1'b0;
    logic        ex_br_taken = 1'b0;
    logic        pc_stall, ifid_stall, ifid_flush, idex_flush;
    logic [31:0] stall_cnt, flush_cnt;

    int checks = 0;
    int fails  = 0;

    hazard_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs1_addr (id_rs1_addr),
        .id_rs2_addr (id_rs2_addr),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .id_rd_addr  (id_rd_addr),
        .id_rd_wren  (id_rd_wren),
        .ex_br_taken (ex_br_taken),
        .pc_stall    (pc_stall),
        .ifid_stall  (ifid_stall),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic wr, input logic br);
        id_valid = v; id_rs1_addr = rs1; id_rs1_used = u1;
        id_rs2_addr = rs2; id_rs2_used = u2;
        id_rd_addr = rd; id_rd_wren = wr; ex_br_taken = br;
    endtask

    task automatic do_reset();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({pc_stall, ifid_stall, ifid_flush, idex_flush} !== 4'b0000) begin
            fails++; $display("FAIL reset_outputs got %b want 0000", {pc_stall, ifid_stall, ifid_flush, idex_flush});
        end
        checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            fails++; $display("FAIL reset_counters got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
        ex_br_taken = 1'b1;
        #1;
        checks++;
        if ({pc_stall, ifid_flush, idex_flush} !== 3'b011) begin
            fails++; $display("FAIL reset_branch got %b want 011", {pc_stall, ifid_flush, idex_flush});
        end
        ex_br_taken = 1'b0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    // add x5,x1,x2 ; add x6,x5,x3
    task automatic test_back_to_back();
        int n;
        do_reset();
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
        #1;
        checks++;
        if (pc_stall !== 1'b0) begin fails++; $display("FAIL b2b_producer got %b want 0", pc_stall); end
        tick();
        set_id(1, 5'd5, 1, 5'd3, 1, 5'd6, 1, 0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (!pc_stall) break;
            n++;
            tick();
        end
        checks++;
        if (n != NCMP) begin fails++; $display("FAIL b2b_stall_cycles got %0d want %0d", n, NCMP); end
        checks++;
        if (stall_cnt !== NCMP) begin fails++; $display("FAIL b2b_stall_cnt got %0d want %0d", stall_cnt, NCMP); end
        checks++;
        if (idex_flush !== 1'b0 || ifid_stall !== 1'b0) begin
            fails++; $display("FAIL b2b_issue got idex=%b ifid_stall=%b want 0 0", idex_flush, ifid_stall);
        end
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // addi x0,x0,1 ; add x7,x0,x0 ; then a reader of x0 on both ports
    task automatic test_x0();
        do_reset();
        set_id(1, 5'd0, 1, 5'd0, 0, 5'd0, 1, 0);
        tick();
        set_id(1, 5'd0, 1, 5'd0, 1, 5'd7, 1, 0);
        #1;
        checks++;
        if (pc_stall !== 1'b0 || idex_flush !== 1'b0) begin
            fails++; $display("FAIL x0_no_stall got stall=%b idex=%b want 0 0", pc_stall, idex_flush);
        end
        checks++;
        if (dut.sb[0].valid !== 1'b0) begin
            fails++; $display("FAIL x0_ex_entry got valid=%b want 0", dut.sb[0].valid);
        end
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // lw x5 in EX, dependent in ID while branch taken
    task automatic test_branch_priority();
        do_reset();
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 0);
        tick();
        set_id(1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 1);
        #1;
        checks++;
        if ({ifid_flush, idex_flush, pc_stall, ifid_stall} !== 4'b1100) begin
            fails++; $display("FAIL br_priority got %b want 1100", {ifid_flush, idex_flush, pc_stall, ifid_stall});
        end
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (flush_cnt !== 32'd1 || stall_cnt !== 32'd0) begin
            fails++; $display("FAIL br_counters got %0d/%0d want 1/0", flush_cnt, stall_cnt);
        end
    endtask

    // addi x6,x5,4 whose rs2 field is x5 too but unused; then rs2 field alone
    task automatic test_rs2_unused();
        do_reset();
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 0);
        tick();
        set_id(1, 5'd9, 1, 5'd5, 0, 5'd6, 1, 0);
        #1;
        checks++;
        if (pc_stall !== 1'b0) begin fails++; $display("FAIL rs2_unused got %b want 0", pc_stall); end
        id_rs1_addr = 5'd5;
        #1;
        checks++;
        if (pc_stall !== 1'b1) begin fails++; $display("FAIL rs1_used got %b want 1", pc_stall); end
        id_rs1_addr = 5'd9; id_rs2_used = 1'b1;
        #1;
        checks++;
        if (pc_stall !== 1'b1) begin fails++; $display("FAIL rs2_used got %b want 1", pc_stall); end
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
        tick();
        set_id(1, 5'd5, 1, 5'd3, 1, 5'd6, 1, 0);
        tick();
        #1;
        checks++;
        if (pc_stall !== 1'b1) begin fails++; $display("FAIL mid_stall_pre got %b want 1", pc_stall); end
        rst = 1'b1;
        #1;
        checks++;
        if (pc_stall !== 1'b0 || stall_cnt !== 32'd0) begin
            fails++; $display("FAIL mid_stall_rst got stall=%b cnt=%0d want 0 0", pc_stall, stall_cnt);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (pc_stall !== 1'b0 || idex_flush !== 1'b0) begin
            fails++; $display("FAIL mid_stall_issue got stall=%b idex=%b want 0 0", pc_stall, idex_flush);
        end
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_saturation();
        do_reset();
        dut.stall_cnt = 32'hFFFF_FFFE;
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
        tick();
        set_id(1, 5'd5, 1, 5'd3, 1, 5'd6, 1, 0);
        for (int i = 0; i < 4; i++) tick();
        #1;
        checks++;
        if (stall_cnt !== 32'hFFFF_FFFF) begin
            fails++; $display("FAIL stall_cnt_sat got %h want ffffffff", stall_cnt);
        end
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reference: register r is busy at cycle t if its latest producer entered EX
    // between 1 and NCMP cycles ago.
    task automatic test_random();
        int last[32];
        int cyc;
        logic raw, br, e_stall;
        logic [31:0] scnt, fcnt;
        do_reset();
        for (int r = 0; r < 32; r++) last[r] = -100;
        cyc = 0; scnt = 0; fcnt = 0;
        for (int n = 0; n < 400; n++) begin
            br = ($urandom_range(0, 99) < 15);
            set_id($urandom_range(0, 9) != 0, 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, br);
            #1;
            raw = id_valid &&
                  ((id_rs1_used && id_rs1_addr != 0 && (cyc - last[id_rs1_addr]) >= 1 && (cyc - last[id_rs1_addr]) <= NCMP) ||
                   (id_rs2_used && id_rs2_addr != 0 && (cyc - last[id_rs2_addr]) >= 1 && (cyc - last[id_rs2_addr]) <= NCMP));
            e_stall = raw && !br;
            checks++;
            if ({pc_stall, ifid_stall, ifid_flush, idex_flush} !== {e_stall, e_stall, br, raw || br}) begin
                fails++; $display("FAIL rand_outputs cyc %0d got %b want %b", cyc,
                    {pc_stall, ifid_stall, ifid_flush, idex_flush}, {e_stall, e_stall, br, raw || br});
            end
            checks++;
            if (stall_cnt !== scnt || flush_cnt !== fcnt) begin
                fails++; $display("FAIL rand_counters cyc %0d got %0d/%0d want %0d/%0d", cyc, stall_cnt, flush_cnt, scnt, fcnt);
            end
            if (id_valid && id_rd_wren && id_rd_addr != 0 && !raw && !br) last[id_rd_addr] = cyc;
            if (e_stall) scnt++;
            if (br) fcnt++;
            tick();
            cyc++;
        end
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_x0();
        test_branch_priority();
        test_rs2_unused();
        test_reset_mid_stall();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
